spi_target_responder: RTL and testbench

// - SPI target (slave) end of the bridge's SPI link: answers transfers from the SPI master path.
// - Oversamples SCLK/CS_N/MOSI in the ACLK domain and shifts bytes in on MOSI and out on MISO.
// - Mode 0 only (CPOL=0, CPHA=0), MSB first by default.
// - Exchanges bytes with local logic over valid/ready ports.

---
 rtl/spi_target_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_target_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_responder.sv
// SPI mode-0 target: oversamples SCLK/CS_N/MOSI in ACLK and exchanges words with local logic via valid/ready.
// Define SPI_TGT_LSB_FIRST_EN for LSB-first shifting; MSB-first is the default build.
module spi_target_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   cs_hist_q, cs_hist_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   miso_q, miso_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   busy_q, busy_d;
    logic                   tx_ready_q, tx_ready_d;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
    logic                   reload_s;
    logic [DATA_W-1:0]      reload_val_s;
    logic [CNT_W-1:0]       cnt_inc_s;

`ifdef SPI_TGT_LSB_FIRST_EN
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh, input logic b);
        return {b, sh[DATA_W-1:1]};
    endfunction
    function automatic logic out_bit(input logic [DATA_W-1:0] sh);
        return sh[0];
    endfunction
`else
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh, input logic b);
        return {sh[DATA_W-2:0], b};
    endfunction
    function automatic logic out_bit(input logic [DATA_W-1:0] sh);
        return sh[DATA_W-1];
    endfunction
`endif

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_hist_q;
    assign sclk_fall_s = ~sclk_s & sclk_hist_q;
    assign cs_fall_s   = ~cs_s & cs_hist_q;
    assign cs_rise_s   = cs_s & ~cs_hist_q;
    assign cnt_inc_s   = cnt_q + CNT_W'(1);

    // Next-state logic: synchronizers, transfer FSM, TX holding register and RX output.
    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], CS_N};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_hist_d   = sclk_s;
        cs_hist_d     = cs_s;
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        reload_s      = 1'b0;
        reload_val_s  = hold_full_q ? hold_q : {DATA_W{1'b0}};

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                cnt_d  = {CNT_W{1'b0}};
                if (cs_fall_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cs_rise_s) begin
                    shift_d = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    reload_s = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    shift_d = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sclk_rise_s) begin
                    shift_d = shift_in(shift_q, mosi_s);
                    cnt_d   = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(DATA_W)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (sclk_fall_s) begin
                    miso_d = out_bit(shift_q);
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ready) begin
                    rx_overrun_d = 1'b1;
                end else begin
                    rx_overrun_d = 1'b0;
                end
                // CS_N still low means the master continues straight into the next word.
                if (!cs_s) begin
                    reload_s = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_SHIFT;
                end else begin
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reload_s) begin
            shift_d       = reload_val_s;
            miso_d        = out_bit(reload_val_s);
            hold_full_d   = 1'b0;
            tx_underrun_d = ~hold_full_q;
        end else begin
            hold_full_d = hold_full_q;
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        busy_d     = (state_d != ST_IDLE);
        tx_ready_d = ~hold_full_d;
    end

    // State registers; synchronizers clear to 0 so CS_N held low at release is not a falling edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            sclk_sync_q   <= {SYNC_STAGES{1'b0}};
            cs_sync_q     <= {SYNC_STAGES{1'b0}};
            mosi_sync_q   <= {SYNC_STAGES{1'b0}};
            sclk_hist_q   <= 1'b0;
            cs_hist_q     <= 1'b0;
            shift_q       <= {DATA_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            hold_q        <= {DATA_W{1'b0}};
            hold_full_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= {DATA_W{1'b0}};
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            busy_q        <= 1'b0;
            tx_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_hist_q   <= sclk_hist_d;
            cs_hist_q     <= cs_hist_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            busy_q        <= busy_d;
            tx_ready_q    <= tx_ready_d;
        end
    end

    assign MISO        = miso_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_target_responder.sv
// Directed bench for spi_target_responder: a mode-0 SPI master model drives the pins and an
// RX scoreboard checks every byte the DUT presents against hand-computed expectations.
module tb_spi_target_responder;

    logic       ACLK = 1'b0;
    logic       ARESETN, SCLK, CS_N, MOSI, MISO;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, tx_underrun, busy;

    typedef struct {
        logic [7:0] d;
        logic       ovr;
    } exp_t;

    exp_t rx_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   rx_evt   = 0;
    int   ucnt     = 0;
    int   ocnt     = 0;
    logic prev_v   = 1'b0;
    logic prev_hs  = 1'b0;

    spi_target_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: a new RX word is presented on a rising rx_valid, after a handshake, or with an overrun.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (tx_underrun) ucnt++;
            if (rx_overrun) ocnt++;
            if (rx_valid && (!prev_v || prev_hs || rx_overrun)) begin
                rx_evt++;
                if (rx_q.size() == 0) begin
                    chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = rx_q.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                    chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, e.ovr});
                end
            end
            prev_v  = rx_valid;
            prev_hs = rx_valid && rx_ready;
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic ovr);
        exp_t e;
        e.d   = d;
        e.ovr = ovr;
        rx_q.push_back(e);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge ACLK);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 50 && !tx_ready; n++) @(negedge ACLK);
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        @(negedge ACLK);
        tx_valid = 1'b0;
    endtask

    // One SCLK period (10 ACLK): MOSI set at the falling edge, MISO sampled just before the rise.
    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        repeat (5) @(negedge ACLK);
        m    = MISO;
        SCLK = 1'b1;
        repeat (5) @(negedge ACLK);
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], b);
            m[i] = b;
        end
    endtask

    task automatic cs_low();
        @(negedge ACLK);
        CS_N = 1'b0;
        repeat (10) @(negedge ACLK);
    endtask

    task automatic cs_high();
        CS_N = 1'b1;
        repeat (10) @(negedge ACLK);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, {31'd0, MISO}, 32'd0);
        chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_rx_overrun"}, {31'd0, rx_overrun}, 32'd0);
        chk({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] m1, m2;
        logic       b;
        int         u0, o0, e0;
        ARESETN = 1'b0; CS_N = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk_reset_vals("rst");
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);

        // Single byte: return 0xA5, receive 0x3C.
        push_tx(8'hA5);
        chk("t1_tx_ready_low", {31'd0, tx_ready}, 32'd0);
        push_exp(8'h3C, 1'b0);
        u0 = ucnt;
        cs_low();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_underrun", ucnt - u0, 32'd0);
        spi_byte(8'h3C, m1);
        chk("t1_miso", {24'd0, m1}, 32'hA5);
        cs_high();
        chk("t1_rx_drained", rx_q.size(), 32'd0);

        // Back-to-back bytes with a refill while the first is shifting.
        push_tx(8'h11);
        push_exp(8'hDE, 1'b0);
        push_exp(8'hAD, 1'b0);
        cs_low();
        push_tx(8'h22);
        repeat (2) @(negedge ACLK);
        spi_byte(8'hDE, m1);
        spi_byte(8'hAD, m2);
        chk("t2_miso0", {24'd0, m1}, 32'h11);
        chk("t2_miso1", {24'd0, m2}, 32'h22);
        cs_high();
        chk("t2_rx_drained", rx_q.size(), 32'd0);

        // Underrun: empty holding register at LOAD.
        push_exp(8'h55, 1'b0);
        u0 = ucnt;
        cs_low();
        chk("t3_underrun", ucnt - u0, 32'd1);
        spi_byte(8'h55, m1);
        chk("t3_miso", {24'd0, m1}, 32'h00);
        cs_high();
        chk("t3_rx_drained", rx_q.size(), 32'd0);

        // Overrun: rx_ready held low across two bytes.
        rx_ready = 1'b0;
        push_exp(8'h01, 1'b0);
        push_exp(8'h02, 1'b1);
        o0 = ocnt;
        cs_low();
        spi_byte(8'h01, m1);
        spi_byte(8'h02, m2);
        cs_high();
        chk("t4_overrun_cnt", ocnt - o0, 32'd1);
        chk("t4_rx_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("t4_rx_data", {24'd0, rx_data}, 32'h02);
        chk("t4_rx_drained", rx_q.size(), 32'd0);
        rx_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("t4_rx_valid_clear", {31'd0, rx_valid}, 32'd0);

        // Abort after 5 SCLK edges, then a clean byte.
        push_tx(8'h99);
        e0 = rx_evt;
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        CS_N = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_tx_ready", {31'd0, tx_ready}, 32'd1);
        repeat (10) @(negedge ACLK);
        chk("t5_no_rx", rx_evt - e0, 32'd0);
        push_exp(8'h77, 1'b0);
        cs_low();
        spi_byte(8'h77, m1);
        cs_high();
        chk("t5_rx_drained", rx_q.size(), 32'd0);

        // Reset after 3 bits; CS_N stays low through release.
        e0 = rx_evt;
        cs_low();
        push_tx(8'h5A);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        ARESETN = 1'b0;
        #1;
        chk_reset_vals("t6");
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 6; i++) spi_bit(1'b0, b);
        repeat (5) @(negedge ACLK);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        chk("t6_no_rx", rx_evt - e0, 32'd0);
        cs_high();
        chk("final_rx_empty", rx_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
